// File: rtl/bus_rr_mux_if.sv
// Shared N-master to 1-slave valid/ready bundle for bus_rr_mux.
// The slave modport is the mux's view; the master modport is the surrounding environment's view.
interface bus_rr_mux_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_MST  = 4
);
  localparam int unsigned SRC_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [N_MST*DATA_W-1:0] m_data;
  logic [N_MST-1:0]        m_valid;
  logic [N_MST-1:0]        m_ready;
  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [SRC_W-1:0]        s_src;

  modport slave (
    input  m_data, m_valid, s_ready,
    output m_ready, s_data, s_valid, s_src
  );

  modport master (
    output m_data, m_valid, s_ready,
    input  m_ready, s_data, s_valid, s_src
  );
endinterface

// File: rtl/bus_rr_mux.sv
// N-master to 1-slave valid/ready mux: round-robin arbitration with bounded bursts,
// feeding a single registered output slice tagged with the source index.
module bus_rr_mux #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_MST     = 4,
  parameter int unsigned BURST_MAX = 1
) (
  input logic           clk,
  input logic           rst,
  bus_rr_mux_if.slave   bus
);
  localparam int unsigned SRC_W = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX);

  logic [DATA_W-1:0] s_data_q;
  logic              s_valid_q;
  logic [SRC_W-1:0]  s_src_q;
  logic [SRC_W-1:0]  ptr_q;
  logic [SRC_W-1:0]  owner_q;
  logic              owner_vld_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              load_en;
  logic              any_valid;
  logic              accept;
  logic              own_hit;
  logic [SRC_W-1:0]  rr_sel;
  logic              rr_found;
  logic [SRC_W-1:0]  rr_idx;
  logic [SRC_W-1:0]  sel;
  logic [CNT_W-1:0]  cnt_next;
  logic [N_MST-1:0]  m_ready_c;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N_MST - 1)) ? '0 : i + 1'b1;
  endfunction

  // First valid master at or after the pointer, wrapping modulo N_MST.
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      rr_idx = SRC_W'((32'(ptr_q) + k) % N_MST);
      if (!rr_found && bus.m_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  always_comb begin
    load_en   = !s_valid_q || bus.s_ready;
    any_valid = |bus.m_valid;
    accept    = load_en && any_valid;
    own_hit   = owner_vld_q && bus.m_valid[owner_q] && (cnt_q < BURST_LAST);
    sel       = own_hit ? owner_q : rr_sel;
    sel_data  = bus.m_data[sel*DATA_W +: DATA_W];
    cnt_next  = (owner_vld_q && (sel == owner_q)) ? cnt_q + 1'b1 : CNT_W'(1);
    m_ready_c = '0;
    if (accept) begin
      m_ready_c[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data_q    <= '0;
      s_valid_q   <= 1'b0;
      s_src_q     <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (load_en) begin
        s_valid_q <= any_valid;
        if (any_valid) begin
          s_data_q <= sel_data;
          s_src_q  <= sel;
        end
      end
      if (accept) begin
        if (cnt_next == BURST_LAST) begin
          owner_vld_q <= 1'b0;
          cnt_q       <= '0;
          ptr_q       <= wrap_inc(sel);
        end else begin
          owner_vld_q <= 1'b1;
          owner_q     <= sel;
          cnt_q       <= cnt_next;
        end
      end else if (owner_vld_q && !bus.m_valid[owner_q]) begin
        // Owner withdrew mid-burst: give up ownership and move past it.
        owner_vld_q <= 1'b0;
        cnt_q       <= '0;
        ptr_q       <= wrap_inc(owner_q);
      end
    end
  end

  assign bus.m_ready = m_ready_c;
  assign bus.s_data  = s_data_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_src   = s_src_q;
endmodule

// File: doc/bus_rr_mux.md
Name: bus_rr_mux

Overview:
- Parametrised N-master to 1-slave valid/ready bus multiplexer with round-robin arbitration, bounded burst hold and a registered output slice.
- Successor to the single master/slave bus pairing: several producers share one consumer channel.
- Sits between producer blocks and a shared slave-side consumer; tags each beat with its source index.

Parameters:
- DATA_W, 8, payload width per beat.
- N_MST, 4, number of master-side channels (>=2).
- BURST_MAX, 1, max consecutive accepted beats granted to one master before forced rotation (>=1).
- SRC_W, derived localparam max(1,$clog2(N_MST)), width of source tag.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_data  input  N_MST*DATA_W  master payloads; channel i at bits [i*DATA_W +: DATA_W].
- m_valid  input  N_MST  per-master beat valid.
- m_ready  output  N_MST  per-master accept; a beat on channel i transfers when m_valid[i] && m_ready[i].
- s_data  output  DATA_W  registered payload to slave.
- s_valid  output  1  registered slave valid.
- s_ready  input  1  slave accept.
- s_src  output  SRC_W  index of the master that produced the current s_data.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, sync release): s_valid=0, s_data=0, s_src=0, rr pointer=0, owner=none, burst count=0. m_ready is combinational and reads 0 while the slice is full and s_ready=0.
- Output slice: single register. load_en = !s_valid || s_ready. Data accepted in cycle N appears on s_* in cycle N+1, giving 1-cycle latency. Full throughput of 1 beat/cycle while s_ready=1.
- Stability: while s_valid=1 && s_ready=0, s_data, s_src and s_valid hold unchanged.
- Grant: exactly one bit of m_ready can be 1, and only when load_en=1. m_ready[i] = load_en && (sel==i) && any m_valid. m_ready does not depend on m_valid of other channels beyond arbitration.
- Selection:
  - If an owner exists, its m_valid=1, and burst count < BURST_MAX, sel = owner.
  - Otherwise sel = first i with m_valid[i]=1, searching ptr, ptr+1, … mod N_MST.
- On each accepted beat:
  - If sel==owner, burst count increments; otherwise owner=sel and burst count=1.
  - If burst count reaches BURST_MAX, ptr=(sel+1) mod N_MST and owner=none.
- If the owner's m_valid drops with no beat accepted: owner=none and ptr=(owner+1) mod N_MST.
- No m_valid asserted: no grant. If load_en, s_valid goes 0 next cycle. ptr is unchanged.
- Simultaneous drain and load (s_valid=1, s_ready=1, a master valid): old beat leaves and new beat loads in the same edge, with no bubble.
- Wrap-around: pointer N_MST-1 advances to 0.
- Reset mid-transfer: in-flight slice content is discarded and all state returns to reset values immediately. After release, arbitration restarts at channel 0.
- Masters must hold m_valid/m_data stable until accepted. The block is not required to tolerate violations.

Test Plan:
- Reset, then all m_valid=0 for 5 cycles -> s_valid=0, s_data=0, s_src=0, m_ready=0 throughout.
- N_MST=4, BURST_MAX=1, all four valid continuously, s_ready=1 -> s_src sequence 0,1,2,3,0,… one beat per cycle, first s_valid one cycle after first accept.
- BURST_MAX=3, masters 1 and 2 valid, s_ready=1 -> s_src 1,1,1,2,2,2,1,1,1.
- Single beat from master 2 (data 8'hAA), s_ready=0 for 4 cycles -> s_data=8'hAA, s_src=2, s_valid=1 held stable, all m_ready=0 until s_ready=1, then one transfer.
- Master 3 only valid after ptr=3, then master 0 -> grant 3 then wrap to 0, data order preserved.
- Assert rst for 1 cycle while s_valid=1 mid-burst -> outputs 0 the same cycle (async), next grant after release goes to lowest valid index from 0.
